// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multicycle MIPS core. Each instruction is stepped
// through fetch / decode / execute / memory / writeback, one step per clock.
// The FSM shares a single ALU, one memory port, the IR, the register file
// and the PC between those steps.
//
// Memory steps (FETCH, MEMRD, MEMWR) wait on a mem_ready handshake. They are
// guarded by a wait counter, and the FSM halts if memory does not answer
// within TIMEOUT_CYCLES. An unknown opcode in DECODE also halts the FSM.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent waiting for mem_ready in one memory step (>=1)
//   TW              wait counter width, 2**TW > TIMEOUT_CYCLES
//
// Ports
//   clk            clock, all state changes on posedge
//   rst_n          asynchronous active-low reset
//   opcode[5:0]    IR[31:26], valid from DECODE onward
//   zero           ALU zero flag (consumed by the datapath together with pc_write_cond)
//   mem_ready      memory access completes this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load when zero=1 (beq)
//   iord           memory address select: 0 PC, 1 ALUOut
//   mem_read       memory read strobe, held until mem_ready
//   mem_write      memory write strobe, held until mem_ready
//   mem_to_reg     register write data: 1 MDR, 0 ALUOut
//   ir_write       load IR from memory data
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   alu_op[1:0]    00 add, 01 sub, 10 R-type funct
//   alu_src_a      0 PC, 1 register A
//   alu_src_b[1:0] 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   reg_write      register file write enable
//   reg_dst        write register select: 1 rd, 0 rt
//   halted         FSM is in HALT
//   halt_cause[1:0] 00 none, 01 illegal opcode, 10 memory timeout
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TW             = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       halted,
    output logic [1:0] halt_cause
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter value seen in the last waiting cycle that is still allowed.
    // If mem_ready is also low in that cycle, the FSM times out.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_MAX     = '1;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      opcode_q, opcode_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]      halt_cause_q, halt_cause_d;

    // Registered Moore outputs. They are decoded from the next state, so each
    // flop already holds the value that belongs to the state being entered.
    logic            pc_write_q, pc_write_d;          // JUMP contribution only
    logic            pc_write_cond_q, pc_write_cond_d;
    logic            iord_q, iord_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic [1:0]      pc_source_q, pc_source_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            alu_src_a_q, alu_src_a_d;
    logic [1:0]      alu_src_b_q, alu_src_b_d;
    logic            reg_write_q, reg_write_d;
    logic            reg_dst_q, reg_dst_d;
    logic            halted_q, halted_d;
    logic            fetch_q, fetch_d;                // in FETCH, qualifies ir_write/pc_write

    logic            waiting;
    logic            timeout_hit;

    // zero gates pc_write_cond inside the datapath.
    // The FSM itself never branches on zero.
    logic            unused_zero;
    assign unused_zero = zero;

    assign waiting     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_hit = waiting && !mem_ready && (wait_cnt_q >= TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        halt_cause_d = halt_cause_q;
        wait_cnt_d   = '0;

        // The counter clears whenever ready arrives or a memory step is left.
        // It saturates rather than wrapping.
        if (waiting && !mem_ready) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + TW'(1);
        end

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d      = S_HALT;
                        halt_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                // The IR may already be changing.
                // Use the opcode latched during DECODE.
                state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default: begin
                state_d      = S_RST;
                halt_cause_d = CAUSE_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode of the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        iord_d          = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        pc_source_d     = 2'b00;
        alu_op_d        = 2'b00;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        reg_write_d     = 1'b0;
        reg_dst_d       = 1'b0;
        halted_d        = 1'b0;
        fetch_d         = 1'b0;

        case (state_d)
            S_FETCH: begin
                fetch_d     = 1'b1;
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;          // PC + 4
            end
            S_DECODE: begin
                alu_src_b_d = 2'b11;          // branch target into ALUOut
            end
            S_MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEMRD: begin
                iord_d      = 1'b1;
                mem_read_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_MEMWR: begin
                iord_d      = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_d = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 2'b01;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 2'b01;
            end
            S_JUMP: begin
                pc_write_d  = 1'b1;
                pc_source_d = 2'b10;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. The reset is asynchronous, so every strobe
    // drops as soon as rst_n falls, even in the middle of an access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_RST;
            opcode_q        <= '0;
            wait_cnt_q      <= '0;
            halt_cause_q    <= CAUSE_NONE;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            iord_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            pc_source_q     <= 2'b00;
            alu_op_q        <= 2'b00;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            reg_write_q     <= 1'b0;
            reg_dst_q       <= 1'b0;
            halted_q        <= 1'b0;
            fetch_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            wait_cnt_q      <= wait_cnt_d;
            halt_cause_q    <= halt_cause_d;
            pc_write_q      <= pc_write_d;
            pc_write_cond_q <= pc_write_cond_d;
            iord_q          <= iord_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            pc_source_q     <= pc_source_d;
            alu_op_q        <= alu_op_d;
            alu_src_a_q     <= alu_src_a_d;
            alu_src_b_q     <= alu_src_b_d;
            reg_write_q     <= reg_write_d;
            reg_dst_q       <= reg_dst_d;
            halted_q        <= halted_d;
            fetch_q         <= fetch_d;
        end
    end

    // In FETCH, the IR load and the PC+4 update happen in the same cycle
    // that the memory returns the instruction.
    assign ir_write      = fetch_q & mem_ready;
    assign pc_write      = pc_write_q | (fetch_q & mem_ready);
    assign pc_write_cond = pc_write_cond_q;
    assign iord          = iord_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign pc_source     = pc_source_q;
    assign alu_op        = alu_op_q;
    assign alu_src_a     = alu_src_a_q;
    assign alu_src_b     = alu_src_b_q;
    assign reg_write     = reg_write_q;
    assign reg_dst       = reg_dst_q;
    assign halted        = halted_q;
    assign halt_cause    = halt_cause_q;

endmodule
